// File: rtl/game_pkg.sv
// ============================================================================
//  game_pkg : grid codes, end-of-game status encoding and controller states
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package game_pkg;

   localparam logic [1:0] GRID_EMPTY  = 2'b00;
   localparam logic [1:0] GRID_MYSHIP = 2'b01;
   localparam logic [1:0] GRID_MISS   = 2'b10;
   localparam logic [1:0] GRID_HIT    = 2'b11;

   localparam logic [1:0] STAT_PLAY  = 2'b00;
   localparam logic [1:0] STAT_WIN   = 2'b01;
   localparam logic [1:0] STAT_LOSE  = 2'b10;
   localparam logic [1:0] STAT_FAULT = 2'b11;

   typedef enum logic [4:0] {
      S_IDLE         = 5'd0,
      S_PLACE_RD     = 5'd1,
      S_PLACE_CHK    = 5'd2,
      S_WAIT_RELEASE = 5'd3,
      S_WAIT_ENEMY   = 5'd4,
      S_DEF_RD       = 5'd5,
      S_DEF_CHK      = 5'd6,
      S_DEF_ANS      = 5'd7,
      S_WAIT_AIM     = 5'd8,
      S_AIM_RD       = 5'd9,
      S_AIM_CHK      = 5'd10,
      S_SHOT         = 5'd11,
      S_WAIT_ANSWER  = 5'd12,
      S_WIN          = 5'd13,
      S_LOSE         = 5'd14,
      S_FAULT        = 5'd15
   } state_t;

endpackage

`default_nettype wire

// File: rtl/answer_timer.sv
// ============================================================================
//  answer_timer : peer-answer timeout with bounded retransmit count
//  Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module answer_timer #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic clear_i,
   input  logic answered_i,
   output logic retx_o,
   output logic fault_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   logic             active_q;
   logic [CNT_W-1:0] cnt_q;
   logic [RTY_W-1:0] rty_q;
   logic             expire;

   // An answer arriving in the expiry cycle suppresses the expiry.
   assign expire  = active_q && !answered_i && (cnt_q == CNT_LAST);
   assign retx_o  = expire && (rty_q != RTY_MAX);
   assign fault_o = expire && (rty_q == RTY_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         rty_q    <= '0;
      end else if (clear_i) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         rty_q    <= '0;
      end else if (start_i) begin
         active_q <= 1'b1;
         cnt_q    <= '0;
         rty_q    <= '0;
      end else if (active_q) begin
         if (answered_i) begin
            active_q <= 1'b0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rty_q == RTY_MAX) begin
               active_q <= 1'b0;
            end else begin
               rty_q <= rty_q + 1'b1;
            end
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/game_ctrl_fsm.sv
// ============================================================================
//  game_ctrl_fsm : battleship placement / attack / defence sequencer
//  Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module game_ctrl_fsm
   import game_pkg::*;
#(
   parameter int CORD_W         = 8,
   parameter int SHIPS_NUMBER   = 10,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 3
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start_btn,
   input  logic                                first_mover,
   input  logic [CORD_W-1:0]                   my_sel_cords,
   input  logic [CORD_W-1:0]                   en_sel_cords,
   output logic [CORD_W-1:0]                   my_mem_addr,
   input  logic [1:0]                          my_mem_rd_data,
   output logic [1:0]                          my_mem_wr_data,
   output logic                                my_mem_we,
   output logic [CORD_W-1:0]                   en_mem_addr,
   input  logic [1:0]                          en_mem_rd_data,
   output logic [1:0]                          en_mem_wr_data,
   output logic                                en_mem_we,
   output logic                                ready_out,
   output logic                                shot_out,
   output logic [CORD_W-1:0]                   cords_out,
   output logic                                ans_valid_out,
   output logic                                ans_hit_out,
   input  logic                                ready_in,
   input  logic                                shot_in,
   input  logic [CORD_W-1:0]                   cords_in,
   input  logic                                ans_valid_in,
   input  logic                                ans_hit_in,
   output logic [$clog2(SHIPS_NUMBER+1)-1:0]   my_ctr,
   output logic [$clog2(SHIPS_NUMBER+1)-1:0]   en_ctr,
   output logic [1:0]                          game_status
);

   localparam int                CTR_W = $clog2(SHIPS_NUMBER + 1);
   localparam logic [CORD_W-1:0] NONE  = '1;
   localparam logic [CTR_W-1:0]  SHIPS = CTR_W'(SHIPS_NUMBER);

   state_t            state_q, state_d;
   logic [CORD_W-1:0] my_addr_q, my_addr_d;
   logic [1:0]        my_wdat_q, my_wdat_d;
   logic              my_we_q, my_we_d;
   logic [CORD_W-1:0] en_addr_q, en_addr_d;
   logic [1:0]        en_wdat_q, en_wdat_d;
   logic              en_we_q, en_we_d;
   logic              ready_q, ready_d;
   logic              shot_q, shot_d;
   logic [CORD_W-1:0] cords_q, cords_d;
   logic              ans_vld_q, ans_vld_d;
   logic              ans_hit_q, ans_hit_d;
   logic [CTR_W-1:0]  my_ctr_q, my_ctr_d;
   logic [CTR_W-1:0]  en_ctr_q, en_ctr_d;
   logic [1:0]        status_q, status_d;

   logic [CTR_W-1:0]  my_dec, en_dec, en_next;
   logic              tmr_retx, tmr_fault;

   assign my_dec  = (my_ctr_q == '0) ? my_ctr_q : my_ctr_q - 1'b1;
   assign en_dec  = (en_ctr_q == '0) ? en_ctr_q : en_ctr_q - 1'b1;
   assign en_next = ans_hit_in ? en_dec : en_ctr_q;

   answer_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_RETRY      (MAX_RETRY)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (state_q == S_SHOT),
      .clear_i    ((state_q != S_SHOT) && (state_q != S_WAIT_ANSWER)),
      .answered_i (ans_valid_in && (state_q == S_WAIT_ANSWER)),
      .retx_o     (tmr_retx),
      .fault_o    (tmr_fault)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         my_addr_q <= '0;
         my_wdat_q <= '0;
         my_we_q   <= 1'b0;
         en_addr_q <= '0;
         en_wdat_q <= '0;
         en_we_q   <= 1'b0;
         ready_q   <= 1'b0;
         shot_q    <= 1'b0;
         cords_q   <= NONE;
         ans_vld_q <= 1'b0;
         ans_hit_q <= 1'b0;
         my_ctr_q  <= SHIPS;
         en_ctr_q  <= SHIPS;
         status_q  <= STAT_PLAY;
      end else begin
         state_q   <= state_d;
         my_addr_q <= my_addr_d;
         my_wdat_q <= my_wdat_d;
         my_we_q   <= my_we_d;
         en_addr_q <= en_addr_d;
         en_wdat_q <= en_wdat_d;
         en_we_q   <= en_we_d;
         ready_q   <= ready_d;
         shot_q    <= shot_d;
         cords_q   <= cords_d;
         ans_vld_q <= ans_vld_d;
         ans_hit_q <= ans_hit_d;
         my_ctr_q  <= my_ctr_d;
         en_ctr_q  <= en_ctr_d;
         status_q  <= status_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      my_addr_d = my_addr_q;
      my_wdat_d = my_wdat_q;
      my_we_d   = 1'b0;
      en_addr_d = en_addr_q;
      en_wdat_d = en_wdat_q;
      en_we_d   = 1'b0;
      ready_d   = ready_q;
      shot_d    = 1'b0;
      cords_d   = cords_q;
      ans_vld_d = 1'b0;
      ans_hit_d = ans_hit_q;
      my_ctr_d  = my_ctr_q;
      en_ctr_d  = en_ctr_q;
      status_d  = status_q;

      case (state_q)
         S_IDLE: begin
            if ((my_sel_cords != NONE) && (my_ctr_q != '0)) begin
               my_addr_d = my_sel_cords;
               state_d   = S_PLACE_RD;
            end else if ((my_ctr_q == '0) && start_btn) begin
               ready_d  = 1'b1;
               my_ctr_d = SHIPS;
               en_ctr_d = SHIPS;
               state_d  = (first_mover && !ready_in) ? S_WAIT_AIM : S_WAIT_ENEMY;
            end
         end
         S_PLACE_RD: state_d = S_PLACE_CHK;
         S_PLACE_CHK: begin
            if (my_mem_rd_data == GRID_EMPTY) begin
               my_wdat_d = GRID_MYSHIP;
               my_we_d   = 1'b1;
               my_ctr_d  = my_dec;
            end
            state_d = S_WAIT_RELEASE;
         end
         // Holding the selection must not place a second cell.
         S_WAIT_RELEASE: begin
            if (my_sel_cords == NONE) state_d = S_IDLE;
         end
         S_WAIT_ENEMY: begin
            if (shot_in) begin
               my_addr_d = cords_in;
               state_d   = S_DEF_RD;
            end
         end
         S_DEF_RD: state_d = S_DEF_CHK;
         S_DEF_CHK: begin
            ans_hit_d = 1'b0;
            if (my_mem_rd_data == GRID_MYSHIP) begin
               my_wdat_d = GRID_HIT;
               my_we_d   = 1'b1;
               my_ctr_d  = my_dec;
               ans_hit_d = 1'b1;
            end else if (my_mem_rd_data == GRID_EMPTY) begin
               my_wdat_d = GRID_MISS;
               my_we_d   = 1'b1;
            end
            state_d = S_DEF_ANS;
         end
         S_DEF_ANS: begin
            ans_vld_d = 1'b1;
            if (my_ctr_q == '0) begin
               status_d = STAT_LOSE;
               state_d  = S_LOSE;
            end else begin
               state_d = S_WAIT_AIM;
            end
         end
         S_WAIT_AIM: begin
            if (en_sel_cords != NONE) begin
               en_addr_d = en_sel_cords;
               state_d   = S_AIM_RD;
            end
         end
         S_AIM_RD: state_d = S_AIM_CHK;
         S_AIM_CHK: state_d = (en_mem_rd_data == GRID_EMPTY) ? S_SHOT : S_WAIT_AIM;
         S_SHOT: begin
            shot_d  = 1'b1;
            cords_d = en_addr_q;
            state_d = S_WAIT_ANSWER;
         end
         S_WAIT_ANSWER: begin
            if (ans_valid_in) begin
               en_addr_d = cords_q;
               en_wdat_d = ans_hit_in ? GRID_HIT : GRID_MISS;
               en_we_d   = 1'b1;
               en_ctr_d  = en_next;
               if (en_next == '0) begin
                  status_d = STAT_WIN;
                  state_d  = S_WIN;
               end else begin
                  state_d = S_WAIT_ENEMY;
               end
            end else if (tmr_fault) begin
               ready_d  = 1'b0;
               status_d = STAT_FAULT;
               state_d  = S_FAULT;
            end else if (tmr_retx) begin
               shot_d = 1'b1;
            end
         end
         S_WIN, S_LOSE, S_FAULT: state_d = state_q;
         default: state_d = S_IDLE;
      endcase
   end

   assign my_mem_addr    = my_addr_q;
   assign my_mem_wr_data = my_wdat_q;
   assign my_mem_we      = my_we_q;
   assign en_mem_addr    = en_addr_q;
   assign en_mem_wr_data = en_wdat_q;
   assign en_mem_we      = en_we_q;
   assign ready_out      = ready_q;
   assign shot_out       = shot_q;
   assign cords_out      = cords_q;
   assign ans_valid_out  = ans_vld_q;
   assign ans_hit_out    = ans_hit_q;
   assign my_ctr         = my_ctr_q;
   assign en_ctr         = en_ctr_q;
   assign game_status    = status_q;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
// ============================================================================
//  tb_game_ctrl_fsm : scoreboard bench with behavioural grid memories
//  Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl_fsm;

   localparam int K_MYW  = 0;
   localparam int K_ENW  = 1;
   localparam int K_ANS  = 2;
   localparam int K_SHOT = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_btn = 1'b0, first_mover = 1'b0;
   logic [7:0] my_sel_cords = 8'hFF, en_sel_cords = 8'hFF;
   logic [7:0] my_mem_addr, en_mem_addr, cords_out;
   logic [1:0] my_mem_rd_data, my_mem_wr_data, en_mem_rd_data, en_mem_wr_data;
   logic       my_mem_we, en_mem_we, ready_out, shot_out, ans_valid_out, ans_hit_out;
   logic       ready_in = 1'b0, shot_in = 1'b0, ans_valid_in = 1'b0, ans_hit_in = 1'b0;
   logic [7:0] cords_in = 8'h00;
   logic [3:0] my_ctr, en_ctr;
   logic [1:0] game_status;

   typedef struct { int k; logic [7:0] a; logic [1:0] d; } ev_t;
   ev_t        sbq[$];
   int         total = 0, bad = 0;
   logic [1:0] my_mem [256];
   logic [1:0] en_mem [256];
   logic [1:0] exp_my [256];
   logic [1:0] exp_en [256];
   logic       mem_clr = 1'b1;
   int         exp_myc = 10, exp_enc = 10;
   logic [7:0] cells [10];

   always #5 clk = ~clk;

   game_ctrl_fsm #(.CORD_W(8), .SHIPS_NUMBER(10), .TIMEOUT_CYCLES(8), .MAX_RETRY(2)) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .first_mover(first_mover),
      .my_sel_cords(my_sel_cords), .en_sel_cords(en_sel_cords),
      .my_mem_addr(my_mem_addr), .my_mem_rd_data(my_mem_rd_data),
      .my_mem_wr_data(my_mem_wr_data), .my_mem_we(my_mem_we),
      .en_mem_addr(en_mem_addr), .en_mem_rd_data(en_mem_rd_data),
      .en_mem_wr_data(en_mem_wr_data), .en_mem_we(en_mem_we),
      .ready_out(ready_out), .shot_out(shot_out), .cords_out(cords_out),
      .ans_valid_out(ans_valid_out), .ans_hit_out(ans_hit_out),
      .ready_in(ready_in), .shot_in(shot_in), .cords_in(cords_in),
      .ans_valid_in(ans_valid_in), .ans_hit_in(ans_hit_in),
      .my_ctr(my_ctr), .en_ctr(en_ctr), .game_status(game_status));

   // Grid memories: synchronous read, one cycle latency.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) begin
            my_mem[i] <= 2'b00;
            en_mem[i] <= 2'b00;
         end
      end else begin
         if (my_mem_we) my_mem[my_mem_addr] <= my_mem_wr_data;
         if (en_mem_we) en_mem[en_mem_addr] <= en_mem_wr_data;
      end
      my_mem_rd_data <= my_mem[my_mem_addr];
      en_mem_rd_data <= en_mem[en_mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input int k, input logic [7:0] a, input logic [1:0] d);
      ev_t e;
      e.k = k; e.a = a; e.d = d;
      sbq.push_back(e);
   endfunction

   task automatic sb_pop(input int k, input logic [7:0] a, input logic [1:0] d);
      ev_t e;
      if (sbq.size() == 0) begin
         chk("unexpected_event_kind", k, 32'hFF);
      end else begin
         e = sbq.pop_front();
         chk("event_kind", k, e.k);
         chk("event_addr", a, e.a);
         chk("event_data", d, e.d);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (my_mem_we)     sb_pop(K_MYW, my_mem_addr, my_mem_wr_data);
         if (en_mem_we)     sb_pop(K_ENW, en_mem_addr, en_mem_wr_data);
         if (ans_valid_out) sb_pop(K_ANS, 8'h00, {1'b0, ans_hit_out});
         if (shot_out)      sb_pop(K_SHOT, cords_out, 2'b00);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && sbq.size() != 0; i++) tick(1);
      chk("sb_drain", sbq.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_clr = 1'b1;
      sbq.delete();
      for (int i = 0; i < 256; i++) begin
         exp_my[i] = 2'b00;
         exp_en[i] = 2'b00;
      end
      exp_myc = 10;
      exp_enc = 10;
      tick(2);
      mem_clr = 1'b0;
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic place(input logic [7:0] c);
      my_sel_cords = c;
      if (exp_my[c] == 2'b00 && exp_myc > 0) begin
         push(K_MYW, c, 2'b01);
         exp_my[c] = 2'b01;
         exp_myc--;
      end
      tick(6);
      my_sel_cords = 8'hFF;
      tick(3);
      drain();
      chk("my_ctr_place", my_ctr, exp_myc);
   endtask

   task automatic place_all();
      for (int i = 0; i < 10; i++) place(cells[i]);
   endtask

   task automatic start_game(input logic fm, input logic rdy);
      first_mover = fm;
      ready_in = rdy;
      start_btn = 1'b1;
      tick(1);
      start_btn = 1'b0;
      tick(2);
      exp_myc = 10;
      exp_enc = 10;
      chk("ready_after_start", ready_out, 1);
      chk("my_ctr_reload", my_ctr, 10);
      chk("en_ctr_reload", en_ctr, 10);
   endtask

   task automatic wait_shot();
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (shot_out) seen = 1;
      end
      if (!seen) chk("shot_wait_timeout", 0, 1);
   endtask

   task automatic answer(input logic [7:0] c, input logic hit);
      ans_valid_in = 1'b1;
      ans_hit_in = hit;
      push(K_ENW, c, hit ? 2'b11 : 2'b10);
      exp_en[c] = hit ? 2'b11 : 2'b10;
      if (hit && exp_enc > 0) exp_enc--;
      tick(1);
      ans_valid_in = 1'b0;
   endtask

   task automatic attack(input logic [7:0] c, input logic hit);
      en_sel_cords = c;
      if (exp_en[c] != 2'b00) begin
         tick(8);
         en_sel_cords = 8'hFF;
         drain();
      end else begin
         push(K_SHOT, c, 2'b00);
         wait_shot();
         en_sel_cords = 8'hFF;
         tick(2);
         answer(c, hit);
         tick(2);
         drain();
      end
      chk("en_ctr_attack", en_ctr, exp_enc);
   endtask

   task automatic defend(input logic [7:0] c);
      shot_in = 1'b1;
      cords_in = c;
      tick(1);
      shot_in = 1'b0;
      if (exp_my[c] == 2'b01) begin
         push(K_MYW, c, 2'b11);
         push(K_ANS, 8'h00, 2'b01);
         exp_my[c] = 2'b11;
         exp_myc--;
      end else if (exp_my[c] == 2'b00) begin
         push(K_MYW, c, 2'b10);
         push(K_ANS, 8'h00, 2'b00);
         exp_my[c] = 2'b10;
      end else begin
         push(K_ANS, 8'h00, 2'b00);
      end
      tick(5);
      drain();
      chk("my_ctr_defend", my_ctr, exp_myc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 10; i++) cells[i] = 8'h40 + 8'(i * 3);
      do_reset();

      chk("rst_my_ctr", my_ctr, 10);
      chk("rst_en_ctr", en_ctr, 10);
      chk("rst_cords", cords_out, 8'hFF);
      chk("rst_ready", ready_out, 0);
      chk("rst_status", game_status, 0);
      chk("rst_shot", shot_out, 0);
      chk("rst_ans_valid", ans_valid_out, 0);
      chk("rst_my_we", my_mem_we, 0);
      chk("rst_my_addr", my_mem_addr, 0);

      // Game A: placement with a duplicate, then play to WIN
      for (int i = 0; i < 5; i++) place(cells[i]);
      place(cells[0]);
      for (int i = 5; i < 10; i++) place(cells[i]);
      chk("placed_all", my_ctr, 0);
      start_game(1'b1, 1'b0);

      ans_valid_in = 1'b1; ans_hit_in = 1'b1;
      tick(1);
      ans_valid_in = 1'b0;
      shot_in = 1'b1; cords_in = cells[1];
      tick(1);
      shot_in = 1'b0;
      tick(4);
      drain();
      chk("stray_en_ctr", en_ctr, 10);
      chk("stray_my_ctr", my_ctr, 10);

      attack(8'h23, 1'b1);
      chk("en_ctr_first_hit", en_ctr, 9);
      defend(cells[0]);
      attack(8'h23, 1'b1);
      attack(8'h24, 1'b0);
      defend(cells[0]);

      en_sel_cords = 8'h30;
      push(K_SHOT, 8'h30, 2'b00);
      wait_shot();
      en_sel_cords = 8'hFF;
      repeat (7) @(posedge clk);
      @(negedge clk);
      answer(8'h30, 1'b1);
      tick(12);
      drain();
      chk("en_ctr_timed_answer", en_ctr, 8);

      defend(8'h99);
      for (int k = 0; k < 8; k++) begin
         attack(8'h50 + 8'(k), 1'b1);
         if (k < 7) defend(8'hA0 + 8'(k));
      end
      chk("win_status", game_status, 2'b01);
      chk("win_ready", ready_out, 1);
      chk("win_en_ctr", en_ctr, 0);
      shot_in = 1'b1; cords_in = cells[2];
      tick(1);
      shot_in = 1'b0;
      tick(6);
      drain();
      chk("win_terminal", game_status, 2'b01);

      // Game B: peer ready first, lose all own cells
      do_reset();
      place_all();
      start_game(1'b1, 1'b1);
      defend(cells[0]);
      for (int i = 1; i < 10; i++) begin
         attack(8'h60 + 8'(i), 1'b0);
         defend(cells[i]);
      end
      chk("lose_status", game_status, 2'b10);
      chk("lose_ready", ready_out, 1);
      chk("lose_my_ctr", my_ctr, 0);

      // Game C: asynchronous reset while waiting for an answer
      do_reset();
      place_all();
      start_game(1'b1, 1'b0);
      en_sel_cords = 8'h11;
      push(K_SHOT, 8'h11, 2'b00);
      wait_shot();
      en_sel_cords = 8'hFF;
      tick(2);
      drain();
      #3 rst_n = 1'b0;
      #1;
      chk("async_cords", cords_out, 8'hFF);
      chk("async_ready", ready_out, 0);
      chk("async_status", game_status, 0);
      chk("async_shot", shot_out, 0);
      chk("async_my_ctr", my_ctr, 10);
      chk("async_en_ctr", en_ctr, 10);
      chk("async_en_addr", en_mem_addr, 0);

      // Game D: no answer, two retransmits, then FAULT
      do_reset();
      place_all();
      start_game(1'b1, 1'b0);
      en_sel_cords = 8'h12;
      push(K_SHOT, 8'h12, 2'b00);
      push(K_SHOT, 8'h12, 2'b00);
      push(K_SHOT, 8'h12, 2'b00);
      wait_shot();
      en_sel_cords = 8'hFF;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (i == 7)  chk("no_early_retx", shot_out, 0);
         if (i == 8)  chk("retx_1", shot_out, 1);
         if (i == 16) chk("retx_2", shot_out, 1);
         if (i == 23) chk("pre_fault_status", game_status, 0);
      end
      chk("fault_status", game_status, 2'b11);
      chk("fault_ready", ready_out, 0);
      tick(10);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Parametrised successor of the single-board battleship controller.
- Sequences ship placement, turn-based shooting and defence over a peer link.
- Owns the read/write ports of the own-board and enemy-board grid memories (1-cycle read latency).
- Adds duplicate-placement and repeat-shot rejection, answer timeout with bounded retransmit, configurable first mover, and explicit end-of-game status.

Parameters:
CORD_W, 8, width of a grid coordinate / memory address; all-ones = "no selection".
SHIPS_NUMBER, 10, ship cells to place; also initial value of both hit counters.
TIMEOUT_CYCLES, 1000000, cycles to wait for a peer answer before retransmitting.
MAX_RETRY, 3, retransmits before entering FAULT.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, asynchronous, active-low
start_btn  in  1  start request, level
first_mover  in  1  1 = this side shoots first when the peer is not yet ready
my_sel_cords  in  CORD_W  cursor cell on own board, all-ones = none
en_sel_cords  in  CORD_W  cursor cell on enemy board, all-ones = none
my_mem_addr  out  CORD_W  own-board address
my_mem_rd_data  in  2  own-board read data
my_mem_wr_data  out  2  own-board write data
my_mem_we  out  1  own-board write enable, 1-cycle pulse
en_mem_addr  out  CORD_W  enemy-board address
en_mem_rd_data  in  2  enemy-board read data
en_mem_wr_data  out  2  enemy-board write data
en_mem_we  out  1  enemy-board write enable, 1-cycle pulse
ready_out  out  1  this side armed / in game
shot_out  out  1  1-cycle shot strobe; qualifies cords_out
cords_out  out  CORD_W  shot coordinate
ans_valid_out  out  1  1-cycle answer strobe
ans_hit_out  out  1  answer result; qualified by ans_valid_out
ready_in  in  1  peer armed
shot_in  in  1  peer shot strobe
cords_in  in  CORD_W  peer shot coordinate
ans_valid_in  in  1  peer answer strobe
ans_hit_in  in  1  peer answer result
my_ctr  out  $clog2(SHIPS_NUMBER+1)  own ship cells remaining
en_ctr  out  $clog2(SHIPS_NUMBER+1)  enemy ship cells remaining
game_status  out  2  00 playing/idle, 01 win, 10 lose, 11 fault

Behaviour:
- Reset values:
  - my_ctr = en_ctr = SHIPS_NUMBER.
  - All other outputs 0, except cords_out = all-ones.
  - State = IDLE.
- Reset asserted mid-game aborts immediately; memories are not cleared by this block.
- All outputs are registered.
- Grid codes: EMPTY 00, MYSHIP 01, MISS 10, HIT 11.
- Placement:
  - IDLE with my_sel_cords != all-ones and my_ctr != 0 -> PLACE_RD: drive my_mem_addr.
  - PLACE_CHK: if data == EMPTY, write MYSHIP and decrement my_ctr; otherwise no write.
  - Then WAIT_RELEASE until my_sel_cords == all-ones, so one selection places exactly one cell.
- IDLE with my_ctr == 0 and start_btn:
  - ready_out = 1; my_ctr and en_ctr reload SHIPS_NUMBER.
  - ready_in = 1 -> WAIT_ENEMY.
  - ready_in = 0 -> WAIT_AIM if first_mover, else WAIT_ENEMY.
- Defence:
  - WAIT_ENEMY on shot_in -> DEF_RD: my_mem_addr = cords_in.
  - DEF_CHK: data MYSHIP -> write HIT, decrement my_ctr, answer hit; data HIT or MISS -> answer miss, no write, no decrement; EMPTY -> write MISS, answer miss.
  - ans_valid_out pulses exactly 1 cycle, 1 cycle after the write.
  - Then: my_ctr == 0 -> LOSE; else WAIT_AIM.
- Attack:
  - WAIT_AIM with en_sel_cords != all-ones -> AIM_RD: en_mem_addr = en_sel_cords.
  - AIM_CHK: data != EMPTY rejects the repeat shot and returns to WAIT_AIM.
  - Otherwise SHOT: shot_out 1-cycle pulse, cords_out latched -> WAIT_ANSWER.
- WAIT_ANSWER:
  - On ans_valid_in: write HIT (decrement en_ctr) or MISS at cords_out; en_ctr == 0 after decrement -> WIN, else WAIT_ENEMY.
  - Timeout counter counts from the SHOT cycle. At TIMEOUT_CYCLES, retransmit the shot (same cords_out) and clear the counter; after MAX_RETRY retransmits go to FAULT.
  - ans_valid_in coinciding with the timeout cycle: the answer wins.
- Unexpected strobes:
  - shot_in outside WAIT_ENEMY is ignored.
  - ans_valid_in outside WAIT_ANSWER is ignored.
- Counters: decrement saturates at 0, never wraps.
- WIN / LOSE / FAULT:
  - Terminal until reset.
  - ready_out = 1 in WIN/LOSE, 0 in FAULT.
  - game_status set on state entry.

Decomposition:
- Package game_pkg: grid code constants, game_status encoding, state enum (5 bits).
- Sub-module answer_timer (TIMEOUT_CYCLES, MAX_RETRY): start/clear/answered inputs; retransmit pulse and fault outputs.

Test Plan:
- Placement: place 10 distinct cells, re-select one already-placed cell -> 10 MYSHIP writes, my_ctr 10 -> 0, no write on the duplicate, no second write while the selection is held.
- Start: start with first_mover = 1, ready_in = 0 -> WAIT_AIM, ready_out = 1. Start with ready_in = 1 -> WAIT_ENEMY.
- Defence: shot_in at a MYSHIP cell -> HIT write, ans_hit_out = 1, my_ctr decremented. Repeat at the same cell -> ans_hit_out = 0, my_ctr unchanged.
- Attack: shoot cell 0x23, ans_valid_in with ans_hit_in = 1 -> en_mem HIT at 0x23, en_ctr 10 -> 9. Re-aim 0x23 -> no shot_out.
- Timeout: TIMEOUT_CYCLES = 8, MAX_RETRY = 2, no answer -> shot_out at cycles 0, 8, 16, then FAULT with game_status = 11. Repeat with an answer in the timeout cycle -> no retransmit.
- End of game: tenth hit answered -> WIN, status 01. Tenth own cell hit -> LOSE, status 10. rst_n low mid-WAIT_ANSWER -> all outputs at reset values asynchronously.
